// File: rtl/vram_dma_pkg.sv
// Shared GPU definitions for the VRAM DMA engine: VRAM geometry, region bounds
// and the transfer state encoding.
package vram_dma_pkg;

  localparam int GPU_VRAM_ADDR_WIDTH = 12;

  // Region bounds are kept as 32-bit values so they compare cleanly against any address width.
  localparam int unsigned PMB_BASE   = 32'h0000_0200;
  localparam int unsigned PMB_LIMIT  = 32'h0000_03FF;
  localparam int unsigned NTBL_BASE  = 32'h0000_0400;
  localparam int unsigned NTBL_LIMIT = 32'h0000_07FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/vram_region_decode.sv
// Maps a VRAM address onto the PMB / NTBL regions; in_range is low for any
// address outside both.
module vram_region_decode
  import vram_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = GPU_VRAM_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] address,
  output logic                  SELECT_pmb,
  output logic                  SELECT_ntbl,
  output logic                  in_range
);

  logic [31:0] addr_ext;

  assign addr_ext    = 32'(address);
  assign SELECT_pmb  = (addr_ext >= PMB_BASE)  && (addr_ext <= PMB_LIMIT);
  assign SELECT_ntbl = (addr_ext >= NTBL_BASE) && (addr_ext <= NTBL_LIMIT);
  assign in_range    = SELECT_pmb || SELECT_ntbl;

endmodule

// File: rtl/vram_dma.sv
// Byte-wide DMA from a 16-bit source bus into VRAM, writing only while vblank
// is high and only into the PMB / NTBL regions.
module vram_dma
  import vram_dma_pkg::*;
#(
  parameter int VRAM_ADDR_WIDTH = GPU_VRAM_ADDR_WIDTH,
  parameter int LEN_WIDTH       = 11
) (
  input  logic                       cpu_clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [15:0]                cfg_src,
  input  logic [VRAM_ADDR_WIDTH-1:0] cfg_dst,
  input  logic [LEN_WIDTH-1:0]       cfg_len,
  input  logic                       vblank,
  output logic                       src_req,
  output logic [15:0]                src_addr,
  input  logic                       src_ack,
  input  logic [7:0]                 src_data,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
  output logic [7:0]                 data_out,
  output logic                       write_enable,
  output logic                       SELECT_pmb,
  output logic                       SELECT_ntbl,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  dma_state_t           state;
  dma_state_t           next_state;
  logic [LEN_WIDTH-1:0] remaining;

  logic latch_cfg;
  logic capture;
  logic advance;
  logic set_err;

  logic dec_pmb;
  logic dec_ntbl;
  logic dst_in_range;

  vram_region_decode #(
    .ADDR_WIDTH (VRAM_ADDR_WIDTH)
  ) u_decode (
    .address     (vram_address),
    .SELECT_pmb  (dec_pmb),
    .SELECT_ntbl (dec_ntbl),
    .in_range    (dst_in_range)
  );

  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    latch_cfg    = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;
    set_err      = 1'b0;
    src_req      = 1'b0;
    write_enable = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            latch_cfg  = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = DONE;
          end
        end
      end
      FETCH: begin
        src_req = 1'b1;
        busy    = 1'b1;
        if (src_ack) begin
          capture    = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        busy = 1'b1;
        // An out-of-range destination ends the transfer whether or not vblank is up.
        if (!dst_in_range) begin
          set_err    = 1'b1;
          next_state = DONE;
        end else if (vblank) begin
          write_enable = 1'b1;
          advance      = 1'b1;
          next_state   = (remaining > LEN_WIDTH'(1)) ? FETCH : DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    // Abort wins over everything: the strobe, the completion pulse and any pending update are dropped.
    if (abort && (state != IDLE)) begin
      next_state   = IDLE;
      capture      = 1'b0;
      advance      = 1'b0;
      set_err      = 1'b0;
      write_enable = 1'b0;
      done         = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      src_addr     <= '0;
      vram_address <= '0;
      remaining    <= '0;
      data_out     <= '0;
      err          <= 1'b0;
    end else begin
      if (latch_cfg) begin
        src_addr     <= cfg_src;
        vram_address <= cfg_dst;
        remaining    <= cfg_len;
        err          <= 1'b0;
      end
      if (capture) begin
        data_out <= src_data;
      end
      if (advance) begin
        src_addr     <= src_addr + 16'd1;
        vram_address <= vram_address + VRAM_ADDR_WIDTH'(1);
        remaining    <= remaining - LEN_WIDTH'(1);
      end
      if (set_err) begin
        err <= 1'b1;
      end
    end
  end

  assign SELECT_pmb  = write_enable && dec_pmb;
  assign SELECT_ntbl = write_enable && dec_ntbl;

endmodule

// File: tb/tb_vram_dma.sv
// Scoreboard bench for vram_dma: a transfer-level model queues expected fetches,
// writes and completions; a negedge monitor pops and compares them.
module tb_vram_dma;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        pmb;
    logic        ntbl;
  } wr_t;

  logic        cpu_clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] cfg_src;
  logic [11:0] cfg_dst;
  logic [10:0] cfg_len;
  logic        vblank;
  logic        src_req;
  logic [15:0] src_addr;
  logic        src_ack;
  logic [7:0]  src_data;
  logic [11:0] vram_address;
  logic [7:0]  data_out;
  logic        write_enable;
  logic        SELECT_pmb;
  logic        SELECT_ntbl;
  logic        busy;
  logic        done;
  logic        err;
  logic [42:0] out_vec;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int done_seen    = 0;
  int done_cyc     = 0;
  int start_cyc    = 0;
  int ack_delay    = 0;
  bit hold_check_en = 1'b0;
  bit vblank_rand   = 1'b0;
  bit vblank_force  = 1'b1;
  bit model_err     = 1'b0;

  logic [15:0] exp_fetch[$];
  wr_t         exp_writes[$];
  bit          exp_done[$];
  int          wr_stamps[$];

  vram_dma dut (
    .cpu_clk      (cpu_clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_src      (cfg_src),
    .cfg_dst      (cfg_dst),
    .cfg_len      (cfg_len),
    .vblank       (vblank),
    .src_req      (src_req),
    .src_addr     (src_addr),
    .src_ack      (src_ack),
    .src_data     (src_data),
    .vram_address (vram_address),
    .data_out     (data_out),
    .write_enable (write_enable),
    .SELECT_pmb   (SELECT_pmb),
    .SELECT_ntbl  (SELECT_ntbl),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  assign out_vec = {src_req, src_addr, vram_address, data_out, write_enable,
                    SELECT_pmb, SELECT_ntbl, busy, done, err};

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  always @(posedge cpu_clk) cyc <= cyc + 1;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Source device: answers each request after ack_delay cycles with a byte derived from the address.
  initial begin : responder
    logic [15:0] held_addr;
    src_ack  = 1'b0;
    src_data = 8'h00;
    forever begin
      @(posedge cpu_clk); #1;
      src_ack = 1'b0;
      if (src_req) begin
        held_addr = src_addr;
        for (int d = 0; d < ack_delay && src_req; d++) begin
          @(posedge cpu_clk); #1;
          if (hold_check_en) begin
            check_output("src_req_held", 64'(src_req), 64'd1);
            check_output("src_addr_held", 64'(src_addr), 64'(held_addr));
          end
        end
        if (src_req) begin
          src_ack  = 1'b1;
          src_data = src_byte(src_addr);
        end
      end
    end
  end

  initial begin : vblank_driver
    vblank = 1'b1;
    forever begin
      @(posedge cpu_clk); #2;
      vblank = vblank_rand ? ($urandom_range(0, 3) != 0) : vblank_force;
    end
  end

  always @(negedge cpu_clk) begin
    if (rst) begin
      if (src_req && src_ack) begin
        if (exp_fetch.size() == 0) begin
          tests_run++; tests_failed++;
          $display("[TB] FAIL unexpected_fetch: got addr %h, expected no fetch", src_addr);
        end else begin
          check_output("fetch_addr", 64'(src_addr), 64'(exp_fetch.pop_front()));
        end
      end
      if (write_enable) begin
        wr_t e;
        wr_stamps.push_back(cyc);
        check_output("write_vblank", 64'(vblank), 64'd1);
        if (exp_writes.size() == 0) begin
          tests_run++; tests_failed++;
          $display("[TB] FAIL unexpected_write: got addr %h, expected no write", vram_address);
        end else begin
          e = exp_writes.pop_front();
          check_output("write_addr", 64'(vram_address), 64'(e.addr));
          check_output("write_data", 64'(data_out), 64'(e.data));
          check_output("write_select", 64'({SELECT_pmb, SELECT_ntbl}), 64'({e.pmb, e.ntbl}));
        end
      end else begin
        check_output("select_idle", 64'({SELECT_pmb, SELECT_ntbl}), 64'd0);
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          tests_run++; tests_failed++;
          $display("[TB] FAIL unexpected_done: got done=1, expected 0 (err=%b)", err);
        end else begin
          check_output("done_err", 64'(err), 64'(exp_done.pop_front()));
        end
      end
    end
  end

  // Transfer-level reference: one fetch per byte, stopping at the first destination outside PMB/NTBL.
  task automatic model_push(input logic [15:0] s, input logic [11:0] d, input int len);
    logic [15:0] sa;
    int          da;
    wr_t         w;
    bit          e;
    e = model_err;
    if (len != 0) begin
      e = 1'b0;
      for (int i = 0; i < len; i++) begin
        sa = s + 16'(i);
        da = int'(d) + i;
        exp_fetch.push_back(sa);
        if (da >= 'h200 && da <= 'h7FF) begin
          w.addr = 12'(da);
          w.data = src_byte(sa);
          w.pmb  = (da <= 'h3FF);
          w.ntbl = (da >= 'h400);
          exp_writes.push_back(w);
        end else begin
          e = 1'b1;
          break;
        end
      end
    end
    model_err = e;
    exp_done.push_back(e);
  endtask

  task automatic issue_start(input logic [15:0] s, input logic [11:0] d, input int len);
    @(posedge cpu_clk); #1;
    cfg_src   = s;
    cfg_dst   = d;
    cfg_len   = 11'(len);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge cpu_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input bit spurious);
    for (int c = 0; c < 3000 && done_seen == n0; c++) begin
      if (spurious && c == 2) begin
        cfg_src = 16'($urandom);
        cfg_dst = 12'h600;
        cfg_len = 11'd9;
        start   = 1'b1;
      end else if (spurious && c == 3) begin
        start = 1'b0;
      end
      @(posedge cpu_clk); #1;
    end
    start = 1'b0;
    check_output("done_pulse_count", 64'(done_seen - n0), 64'd1);
  endtask

  task automatic apply_stimulus(input logic [15:0] s, input logic [11:0] d, input int len,
                                input bit spurious);
    int n0;
    n0 = done_seen;
    model_push(s, d, len);
    issue_start(s, d, len);
    wait_done(n0, spurious);
  endtask

  task automatic wait_in_write(input string name);
    for (int c = 0; c < 40 && !(busy && !src_req); c++) begin
      @(posedge cpu_clk); #1;
    end
    check_output(name, 64'({busy, src_req}), 64'b10);
  endtask

  initial begin : main
    logic [15:0] s;
    logic [11:0] d;
    int          len;
    int          n0;
    int          vb_cyc;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    #2 rst = 1'b0;
    #1 check_output("reset_outputs", 64'(out_vec), 64'd0);
    @(posedge cpu_clk);
    @(posedge cpu_clk); #1 rst = 1'b1;

    // Four PMB bytes back to back: 2-cycle spacing, done one cycle after the last write.
    ack_delay = 0; vblank_force = 1'b1; vblank_rand = 1'b0;
    wr_stamps.delete();
    apply_stimulus(16'h1000, 12'h200, 4, 1'b0);
    check_output("pmb_write_count", 64'(wr_stamps.size()), 64'd4);
    if (wr_stamps.size() == 4) begin
      check_output("first_write_latency", 64'(wr_stamps[0] - start_cyc), 64'd2);
      for (int i = 1; i < 4; i++)
        check_output("write_spacing", 64'(wr_stamps[i] - wr_stamps[i-1]), 64'd2);
      check_output("done_after_last", 64'(done_cyc - wr_stamps[3]), 64'd1);
    end

    // Running off the end of NTBL: two writes then err.
    apply_stimulus(16'h2000, 12'h7FE, 4, 1'b0);
    check_output("err_sticky", 64'(err), 64'd1);

    // vblank low for 10 cycles in WRITE holds the write.
    vblank_force = 1'b0;
    wr_stamps.delete();
    n0 = done_seen;
    model_push(16'h0123, 12'h300, 1);
    issue_start(16'h0123, 12'h300, 1);
    check_output("err_cleared_on_start", 64'(err), 64'd0);
    wait_in_write("hold_reached_write");
    for (int i = 0; i < 10; i++) begin
      @(negedge cpu_clk);
      check_output("hold_no_write", 64'(write_enable), 64'd0);
      check_output("hold_address", 64'(vram_address), 64'h300);
      @(posedge cpu_clk); #1;
    end
    vblank_force = 1'b1;
    vb_cyc = cyc;
    wait_done(n0, 1'b0);
    check_output("write_on_first_vblank", 64'(wr_stamps.size() == 1 ? wr_stamps[0] : -1),
                 64'(vb_cyc));

    // Source wrap with a slow source; a start during the transfer must be ignored.
    ack_delay = 5; hold_check_en = 1'b1;
    apply_stimulus(16'hFFFF, 12'h210, 2, 1'b1);
    hold_check_en = 1'b0; ack_delay = 0;

    // Zero length: done on the next cycle, nothing else.
    apply_stimulus(16'h4444, 12'h250, 0, 1'b0);
    check_output("len0_done_latency", 64'(done_cyc - start_cyc), 64'd1);

    // Abort in WRITE while vblank rises: no write, no done, busy drops.
    vblank_force = 1'b0;
    exp_fetch.push_back(16'h0040);
    issue_start(16'h0040, 12'h250, 3);
    wait_in_write("abort_reached_write");
    abort = 1'b1; vblank_force = 1'b1;
    @(negedge cpu_clk);
    check_output("abort_no_write", 64'(write_enable), 64'd0);
    @(posedge cpu_clk); #1;
    abort = 1'b0;
    check_output("abort_busy_drop", 64'(busy), 64'd0);
    repeat (4) begin
      @(negedge cpu_clk);
      check_output("abort_stays_idle", 64'({busy, src_req, done}), 64'd0);
    end

    // Reset in the middle of a slow fetch: everything clears at once and the transfer is gone.
    ack_delay = 20;
    issue_start(16'h0500, 12'h220, 3);
    #2;
    check_output("rst_pre_fetch", 64'(src_req), 64'd1);
    rst = 1'b0;
    #1 check_output("rst_async_outputs", 64'(out_vec), 64'd0);
    @(posedge cpu_clk); #1 rst = 1'b1;
    model_err = 1'b0;
    repeat (25) begin
      @(negedge cpu_clk);
      check_output("rst_no_resume", 64'({busy, src_req, write_enable}), 64'd0);
    end
    ack_delay = 0;

    // Randomised transfers with jittery vblank and source latency.
    vblank_rand = 1'b1;
    for (int n = 0; n < 14; n++) begin
      ack_delay = $urandom_range(0, 3);
      s   = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 4)) : 16'($urandom);
      d   = 12'($urandom_range('h1F8, 'h808));
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 40) : $urandom_range(0, 6);
      apply_stimulus(s, d, len, 1'b0);
    end
    vblank_rand = 1'b0;

    repeat (3) @(posedge cpu_clk);
    check_output("leftover_fetches", 64'(exp_fetch.size()), 64'd0);
    check_output("leftover_writes", 64'(exp_writes.size()), 64'd0);
    check_output("leftover_dones", 64'(exp_done.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
